// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the memory stage: icodes, memory-stage FSM states
// and the operation class produced by decode.
package y86_pkg;

  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational memory-stage decode: selects the op class, the address source
// and the write-data source from the instruction code.
module mem_op_decode
  import y86_pkg::*;
(
  input  logic        [3:0]  icode,
  input  logic signed [63:0] val_a,
  input  logic signed [63:0] val_e,
  input  logic signed [63:0] val_p,
  output op_t                op_cls,
  output logic        [63:0] addr,
  output logic        [63:0] wdata
);

  always_comb begin
    op_cls = OP_NONE;
    addr   = val_e;
    wdata  = val_a;
    case (icode)
      IMRMOVQ:       op_cls = OP_READ;
      IRET, IPOPQ: begin
        op_cls = OP_READ;
        addr   = val_a;
      end
      IRMMOVQ, IPUSHQ: op_cls = OP_WRITE;
      ICALL: begin
        op_cls = OP_WRITE;
        wdata  = val_p;
      end
      default: op_cls = OP_NONE;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Y86-64 memory-stage access controller: captures one operation, runs a single
// request/ack handshake with timeout, and reports the result and sticky errors.
//
// state   | meaning
// S_IDLE  | waiting for start; captures the operation
// S_ISSUE | mem_req high, waiting for mem_ack or timeout
// S_DONE  | one-cycle completion pulse
module mem_access_ctrl
  import y86_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic        [3:0]  icode,
  input  logic signed [63:0] val_A,
  input  logic signed [63:0] val_E,
  input  logic signed [63:0] val_P,
  output logic               mem_req,
  output logic               mem_we,
  output logic        [63:0] mem_addr,
  output logic        [63:0] mem_wdata,
  input  logic               mem_ack,
  input  logic        [63:0] mem_rdata,
  input  logic               mem_err,
  output logic signed [63:0] val_M,
  output logic               busy,
  output logic               done,
  output logic               dmem_er
);

  localparam int CW = $clog2(TIMEOUT + 1);

  op_t         dec_cls;
  logic [63:0] dec_addr;
  logic [63:0] dec_wdata;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] val_m_q, val_m_d;
  logic        err_q, err_d;

  mem_op_decode u_dec (
    .icode  (icode),
    .val_a  (val_A),
    .val_e  (val_E),
    .val_p  (val_P),
    .op_cls (dec_cls),
    .addr   (dec_addr),
    .wdata  (dec_wdata)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    val_m_d = val_m_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = dec_cls;
          addr_d  = dec_addr;
          wdata_d = dec_wdata;
          we_d    = (dec_cls == OP_WRITE);
          cnt_d   = '0;
          if (dec_cls == OP_NONE) begin
            state_d = S_DONE;
          end else if (dec_addr > 64'(MEM_WORDS - 1)) begin
            // Unsigned compare: negative addresses fault here too.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          if (mem_err) err_d = 1'b1;
          else if (op_q == OP_READ) val_m_d = mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      val_m_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      val_m_q <= val_m_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign val_M     = val_m_q;
  assign dmem_er   = err_q;

endmodule
